// File: rtl/core_pkg.sv
// Shared types for the hps_io block-device front end: FSM states, request
// direction, the latched per-channel request and the grant-time validity check.
package core_pkg;

   localparam int SD_SECTOR_WORDS = 256;

   typedef enum logic [2:0] {
      IDLE,
      GRANT,
      REQ,
      XFER,
      DONE,
      ERR
   } sd_arb_state_t;

   typedef enum logic {
      DIR_RD = 1'b0,
      DIR_WR = 1'b1
   } sd_dir_t;

   typedef struct packed {
      logic [31:0] lba;
      sd_dir_t     dir;
   } sd_req_t;

   // A request may go out to the HPS only if the disk is mounted, the sector
   // lies inside the image, and it does not write to a read-only image.
   function automatic logic sd_req_ok(input sd_req_t     req,
                                      input logic        mounted,
                                      input logic        readonly,
                                      input logic [31:0] sectors);
      return mounted && (req.lba < sectors) && !((req.dir == DIR_WR) && readonly);
   endfunction

endpackage

// File: rtl/sd_rr_arb.sv
// Round-robin arbiter: the search starts at the channel after the last one
// granted; the pointer moves only when the advance strobe accepts a winner.
module sd_rr_arb #(
   parameter  int N  = 2,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic [N-1:0]  i_req,
   input  logic          i_adv,
   output logic [N-1:0]  o_grant,
   output logic [IW-1:0] o_idx,
   output logic          o_valid
);

   logic [IW-1:0] r_ptr;

   always_comb begin
      o_valid = 1'b0;
      o_idx   = '0;
      o_grant = '0;
      for (int k = 0; k < N; k++) begin
         if (!o_valid && i_req[(int'(r_ptr) + k) % N]) begin
            o_valid = 1'b1;
            o_idx   = IW'((int'(r_ptr) + k) % N);
         end
      end
      if (o_valid) begin
         o_grant[o_idx] = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_ptr <= '0;
      end else if (i_adv && o_valid) begin
         r_ptr <= (o_idx == IW'(N - 1)) ? '0 : o_idx + 1'b1;
      end
   end

endmodule

// File: rtl/sd_blk_arb.sv
// Block-device front end: arbitrates single-sector client requests onto the
// shared hps_io sd_* interface and steers the sector stream to/from the winner.
module sd_blk_arb
   import core_pkg::*;
#(
   parameter int NUM_VD  = 2,
   parameter int TIMEOUT = 2**20
) (
   input  logic                   clk_sys,
   input  logic                   reset,
   input  logic [NUM_VD-1:0]      img_mounted,
   input  logic                   img_readonly,
   input  logic [63:0]            img_size,
   output logic [31:0]            sd_lba,
   output logic [NUM_VD-1:0]      sd_rd,
   output logic [NUM_VD-1:0]      sd_wr,
   input  logic [NUM_VD-1:0]      sd_ack,
   input  logic [7:0]             sd_buff_addr,
   input  logic [15:0]            sd_buff_dout,
   input  logic                   sd_buff_wr,
   output logic [15:0]            sd_buff_din,
   input  logic [NUM_VD-1:0]      cli_rd,
   input  logic [NUM_VD-1:0]      cli_wr,
   input  logic [NUM_VD*32-1:0]   cli_lba,
   output logic [NUM_VD-1:0]      cli_busy,
   output logic [NUM_VD-1:0]      cli_done,
   output logic [NUM_VD-1:0]      cli_err,
   output logic [NUM_VD-1:0]      cli_mounted,
   output logic [NUM_VD-1:0]      cli_ro,
   output logic [NUM_VD*32-1:0]   cli_sectors,
   output logic [NUM_VD-1:0]      cli_sel,
   output logic [7:0]             cli_addr,
   output logic                   cli_we,
   output logic [15:0]            cli_wdata,
   input  logic [NUM_VD*16-1:0]   cli_rdata
);

   localparam int CHW = (NUM_VD > 1) ? $clog2(NUM_VD) : 1;
   localparam int TW  = $clog2(TIMEOUT + 1);
   localparam int AW  = $clog2(SD_SECTOR_WORDS);

   sd_arb_state_t     r_state;
   sd_arb_state_t     w_state_nxt;
   logic [NUM_VD-1:0] r_pend;
   sd_req_t           r_req [NUM_VD];
   logic [NUM_VD-1:0] r_mnt;
   logic [NUM_VD-1:0] r_ro;
   logic [31:0]       r_sect [NUM_VD];
   logic [CHW-1:0]    r_ch;
   logic [TW-1:0]     r_cnt;

   logic [NUM_VD-1:0] w_arb_grant;
   logic [CHW-1:0]    w_arb_idx;
   logic              w_arb_valid;
   logic              w_arb_adv;
   sd_req_t           w_cur;
   logic              w_cur_ok;
   logic [TW-1:0]     w_cnt_inc;
   logic [15:0]       w_rdata_sel;
   logic [AW-1:0]     w_addr;

   assign w_arb_adv = (r_state == IDLE);

   sd_rr_arb #(
      .N (NUM_VD)
   ) u_rr_arb (
      .i_clk   (clk_sys),
      .i_reset (reset),
      .i_req   (r_pend),
      .i_adv   (w_arb_adv),
      .o_grant (w_arb_grant),
      .o_idx   (w_arb_idx),
      .o_valid (w_arb_valid)
   );

   assign w_cur       = r_req[r_ch];
   assign w_cur_ok    = sd_req_ok(w_cur, r_mnt[r_ch], r_ro[r_ch], r_sect[r_ch]);
   assign w_cnt_inc   = (r_cnt == TW'(TIMEOUT)) ? r_cnt : r_cnt + 1'b1;
   assign w_rdata_sel = cli_rdata[int'(r_ch) * 16 +: 16];
   assign w_addr      = sd_buff_addr;

   assign cli_busy    = r_pend;
   assign cli_mounted = r_mnt;
   assign cli_ro      = r_ro;
   assign cli_addr    = w_addr;
   assign cli_wdata   = sd_buff_dout;

   for (genvar g = 0; g < NUM_VD; g++) begin : g_sect
      assign cli_sectors[g*32 +: 32] = r_sect[g];
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_state <= IDLE;
         r_ch    <= '0;
      end else begin
         r_state <= w_state_nxt;
         if ((r_state == IDLE) && w_arb_valid && (|w_arb_grant)) begin
            r_ch <= w_arb_idx;
         end
      end
   end

   // Cleared on entering REQ so the budget is measured from sd_rd/sd_wr rise.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (r_state == GRANT) begin
         r_cnt <= '0;
      end else if (r_state == REQ) begin
         r_cnt <= w_cnt_inc;
      end
   end

   // A channel's pending bit doubles as its busy flag, so new pulses are
   // dropped until DONE/ERR releases it.
   always_ff @(posedge clk_sys) begin
      for (int i = 0; i < NUM_VD; i++) begin
         if (reset) begin
            r_pend[i]     <= 1'b0;
            r_req[i].lba  <= '0;
            r_req[i].dir  <= DIR_RD;
         end else if (((r_state == DONE) || (r_state == ERR)) && (r_ch == CHW'(i))) begin
            r_pend[i] <= 1'b0;
         end else if (!r_pend[i] && (cli_rd[i] || cli_wr[i])) begin
            r_pend[i]    <= 1'b1;
            r_req[i].lba <= cli_lba[i*32 +: 32];
            r_req[i].dir <= cli_rd[i] ? DIR_RD : DIR_WR;
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      for (int i = 0; i < NUM_VD; i++) begin
         if (reset) begin
            r_mnt[i]  <= 1'b0;
            r_ro[i]   <= 1'b0;
            r_sect[i] <= '0;
         end else if (img_mounted[i]) begin
            r_mnt[i]  <= |img_size;
            r_ro[i]   <= img_readonly;
            r_sect[i] <= img_size[40:9];
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      sd_lba      = '0;
      sd_rd       = '0;
      sd_wr       = '0;
      sd_buff_din = '0;
      cli_sel     = '0;
      cli_done    = '0;
      cli_err     = '0;
      cli_we      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_arb_valid) begin
               w_state_nxt = GRANT;
            end
         end
         GRANT: begin
            w_state_nxt = w_cur_ok ? REQ : ERR;
         end
         REQ: begin
            sd_lba        = w_cur.lba;
            cli_sel[r_ch] = 1'b1;
            sd_buff_din   = w_rdata_sel;
            if (w_cur.dir == DIR_RD) begin
               sd_rd[r_ch] = 1'b1;
            end else begin
               sd_wr[r_ch] = 1'b1;
            end
            if (sd_ack[r_ch]) begin
               w_state_nxt = XFER;
            end else if (w_cnt_inc == TW'(TIMEOUT)) begin
               w_state_nxt = ERR;
            end
         end
         XFER: begin
            sd_lba        = w_cur.lba;
            cli_sel[r_ch] = 1'b1;
            sd_buff_din   = w_rdata_sel;
            cli_we        = sd_buff_wr && (w_cur.dir == DIR_RD);
            if (!sd_ack[r_ch]) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            cli_done[r_ch] = 1'b1;
            w_state_nxt    = IDLE;
         end
         ERR: begin
            cli_err[r_ch] = 1'b1;
            w_state_nxt   = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: doc/sd_blk_arb.md
# sd_blk_arb

Parametrised block-device front end between the MiSTer hps_io `sd_*` sector interface and up to `NUM_VD` core-side clients (backup SRAM, BMP cartridge, future CD/save images). Each client issues single-sector read or write requests. The block:
- round-robin arbitrates the requests onto the shared `sd_lba` bus;
- drives the per-disk `sd_rd`/`sd_wr` handshake and steers the 256-word sector stream to or from the granted client;
- tracks mount state, size and read-only status per disk;
- rejects invalid requests and times out dead transfers.

## Interface
Parameters:
- `NUM_VD`, 2, number of virtual disks/clients (1..4)
- `TIMEOUT`, 2**20, clk_sys cycles allowed from request assert to `sd_ack` rise

Ports:
- `clk_sys`  in  1  core clock
- `reset`  in  1  synchronous, active-high
- `img_mounted`  in  NUM_VD  per-disk mount strobe (one cycle)
- `img_readonly`  in  1  read-only flag, valid with `img_mounted`
- `img_size`  in  64  image bytes, valid with `img_mounted`; 0 = unmounted
- `sd_lba`  out  32  sector address of the granted request
- `sd_rd`, `sd_wr`  out  NUM_VD  per-disk request levels
- `sd_ack`  in  NUM_VD  per-disk acknowledge
- `sd_buff_addr`  in  8  word index within the sector
- `sd_buff_dout`  in  16  read data from HPS
- `sd_buff_wr`  in  1  read-data strobe
- `sd_buff_din`  out  16  write data to HPS (mux of `cli_rdata`)
- `cli_rd`, `cli_wr`  in  NUM_VD  request pulses
- `cli_lba`  in  NUM_VD×32  request sector
- `cli_busy`  out  NUM_VD  request pending or active
- `cli_done`, `cli_err`  out  NUM_VD  completion pulses (one cycle)
- `cli_mounted`, `cli_ro`  out  NUM_VD  latched mount state
- `cli_sectors`  out  NUM_VD×32  `img_size[40:9]`
- `cli_sel`  out  NUM_VD  one-hot active channel, 0 when idle
- `cli_addr`  out  8  = `sd_buff_addr`
- `cli_we`  out  1  write strobe into the client RAM (`sd_buff_wr` gated by `cli_sel`, read transfers only)
- `cli_wdata`  out  16  = `sd_buff_dout`
- `cli_rdata`  in  NUM_VD×16  client RAM data at `cli_addr`, combinational or 1-cycle registered

## Operation
- **Pending capture.** `cli_rd`/`cli_wr` pulses set a per-channel pending bit and latch `cli_lba` and the direction. Rd wins if both pulse together. Pulses arriving while that channel is busy are ignored. `cli_busy` rises the cycle after the pulse.
- **Validation at grant.** Any of the following ends the request with a `cli_err` pulse and no sd request; it takes 1 cycle:
  - channel not mounted;
  - `lba >= cli_sectors`;
  - write to a read-only disk.
- **FSM states:**
  - IDLE → GRANT when any channel is pending; the winner is chosen by round-robin starting after the last granted channel.
  - GRANT: validate. Invalid → ERR. Valid → REQ; drive `sd_lba`, assert `sd_rd[i]` or `sd_wr[i]`, set `cli_sel[i]`.
  - REQ: hold the request. `sd_ack[i]` high → XFER and drop `sd_rd`/`sd_wr` the same cycle. Timeout counter reaching `TIMEOUT` → ERR.
  - XFER: `sd_ack[i]` falling → DONE.
  - DONE: pulse `cli_done[i]`, clear pending and busy, go to IDLE.
  - ERR: pulse `cli_err[i]`, clear pending and busy, go to IDLE; `sd_rd`/`sd_wr` is already low.
- **Mount.** `img_mounted[i]` latches `img_readonly` and the size at any time. `img_size==0` clears `cli_mounted`. A mount during an active transfer on that channel does not alter it; the new geometry applies from the next GRANT.
- **Data steering.** `cli_we` is asserted only in XFER of a read. `sd_buff_din` shows `cli_rdata[sel]`, or 0 when idle.

## Timing
- **Reset values:** all outputs 0, including pending bits, mount state, arbiter pointer (channel 0 first) and timeout counter.
- **Reset mid-transfer:** `sd_rd`/`sd_wr` drop the next edge; no done or err pulse is issued.
- **Latency:**
  - request pulse → `sd_rd` high: 3 cycles from idle (capture, IDLE→GRANT, GRANT→REQ);
  - `sd_ack` fall → `cli_done`: 1 cycle;
  - invalid request pulse → `cli_err`: 3 cycles.
- **Timeout counter:** width `$clog2(TIMEOUT+1)`; zeroed on entering REQ; saturates.
- **Back-to-back:** GRANT is re-entered at the earliest 1 cycle after DONE; a channel cannot win twice in a row while another is pending.
- **Ack outside REQ/XFER:** an `sd_ack` for a non-granted channel is ignored.

## Structure
- In `core_pkg`:
  - `SD_SECTOR_WORDS = 256`;
  - `typedef enum` `sd_arb_state_t` {IDLE, GRANT, REQ, XFER, DONE, ERR};
  - `typedef struct` for the per-channel latched request (lba, dir).
- Sub-module `sd_rr_arb`: parameterised round-robin arbiter (req vector, advance strobe → one-hot grant, pointer register).

## Test plan
- Mount vd0 with 8192 bytes; read LBA 3; TB server streams 256 words `16'h0300+n` → 256 `cli_we` strobes with matching `cli_addr`/`cli_wdata`, then `sd_rd[0]` low after ack and one `cli_done[0]`.
- Mount vd1 read-only; `cli_wr[1]` LBA 0 → `cli_err[1]` 3 cycles later, `sd_wr` never asserted.
- vd0 and vd1 mounted, both pulse reads at the same cycle, repeat 3× → grant order 0,1,0,1,0,1 and `sd_lba` matches each channel's LBA.
- Read LBA 16 on a 16-sector image → `cli_err`, no `sd_rd`. Then `TIMEOUT=64` with the server silent → `sd_rd` held exactly 64 cycles, then `cli_err`.
- Write LBA 2 on vd0; client RAM holds `16'hA500+n` → file bytes match with the client's 1-cycle registered `cli_rdata`.
- Assert `reset` during XFER at word 100 → all outputs 0 next cycle, no done; a subsequent read completes normally.
